// File: rtl/if_pkg.sv
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with write-enable hold and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        write,
    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // A write with valid_in low loads the bubble rather than the inputs.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (write) begin
            instr    <= valid_in ? instr_in    : NOP_INSTR;
            pc_plus4 <= valid_in ? pc_plus4_in : 32'h0;
            valid    <= valid_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage: PC, fetch FSM, hold buffer, IF/ID.
//               Optional perf counters enabled by IF_PERF_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        ifWrite,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
`ifdef IF_PERF_COUNTERS_EN
    output logic [31:0] stallCount,
    output logic [31:0] flushCount,
`endif
    output logic [31:0] pc
);

    if_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_hold_buf;
    logic        r_req;

    if_state_t   w_state_next;
    logic [31:0] w_pc_next;
    logic        w_ifid_write;
    logic        w_ifid_valid_in;
    logic [31:0] w_ifid_instr_in;
    logic        w_hold_load;
    logic        w_addr_load;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_addr_plus4;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_addr_plus4 = r_addr + 32'd4;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ifid_write    = 1'b0;
        w_ifid_valid_in = 1'b0;
        w_ifid_instr_in = NOP_INSTR;
        w_hold_load     = 1'b0;
        if (branchTaken) begin
            // An in-flight request must still be drained before refetching.
            w_pc_next    = branchTarget;
            w_state_next = ((r_state == S_REQ || r_state == S_DROP) && !imemReady)
                           ? S_DROP : S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imemReady) begin
                        if (ifWrite) begin
                            w_ifid_write    = 1'b1;
                            w_ifid_valid_in = 1'b1;
                            w_ifid_instr_in = imemData;
                            if (pcWrite) w_pc_next = w_pc_plus4;
                        end else begin
                            w_hold_load  = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end else begin
                        w_ifid_write = ifWrite;
                    end
                end
                S_HOLD: begin
                    if (ifWrite) begin
                        w_ifid_write    = 1'b1;
                        w_ifid_valid_in = 1'b1;
                        w_ifid_instr_in = r_hold_buf;
                        if (pcWrite) w_pc_next = w_pc_plus4;
                        w_state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    w_ifid_write = ifWrite;
                    if (imemReady) w_state_next = S_REQ;
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    // A new request starts whenever S_REQ is entered or a response completes in it.
    assign w_addr_load = (w_state_next == S_REQ) && ((r_state != S_REQ) || imemReady);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_hold_buf <= NOP_INSTR;
            r_req      <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_req   <= (w_state_next != S_HOLD);
            if (w_addr_load) r_addr <= w_pc_next;
            if (w_hold_load) r_hold_buf <= imemData;
        end
    end

    assign imemReq  = r_req;
    assign imemAddr = r_addr;
    assign pc       = r_pc;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .flush       (branchTaken),
        .write       (w_ifid_write),
        .valid_in    (w_ifid_valid_in),
        .instr_in    (w_ifid_instr_in),
        .pc_plus4_in (w_addr_plus4),
        .instr       (ifIdInstr),
        .pc_plus4    (ifIdPcPlus4),
        .valid       (ifIdValid)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (!ifWrite && !branchTaken && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (branchTaken && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pcWrite, input, 1, from stall control; 0 holds the PC.
REQ-005 SHALL have port ifWrite, input, 1, from stall control; 0 holds the IF/ID register.
REQ-006 SHALL have port branchTaken, input, 1, redirect request that flushes IF/ID.
REQ-007 SHALL have port branchTarget, input, 32, redirect PC.
REQ-008 SHALL have port imemReq, output, 1, instruction-memory request.
REQ-009 SHALL have port imemAddr, output, 32, request address, stable while imemReq is high.
REQ-010 SHALL have port imemReady, input, 1, response valid, single-cycle pulse.
REQ-011 SHALL have port imemData, input, 32, instruction word, valid when imemReady=1.
REQ-012 SHALL have ports ifIdInstr, ifIdPcPlus4 (output, 32) and ifIdValid (output, 1), the IF/ID register.
REQ-013 SHALL have port pc, output, 32, the current fetch PC.

Function
REQ-014 FSM states SHALL be S_REQ, S_HOLD and S_DROP; imemReq=1 in S_REQ and S_DROP and 0 in S_HOLD.
REQ-015 On entering S_REQ, the address register SHALL latch pc; imemAddr SHALL not change until imemReady.
REQ-016 In S_REQ with imemReady=1, branchTaken=0 and ifWrite=1: IF/ID SHALL take {imemData, imemAddr+4, valid=1}, and pc SHALL become pc+4 if pcWrite=1; the state stays S_REQ.
REQ-017 In S_REQ with imemReady=1, branchTaken=0 and ifWrite=0: IF/ID SHALL hold, imemData SHALL be captured into a hold buffer, pc SHALL hold, and the next state SHALL be S_HOLD.
REQ-018 In S_REQ with imemReady=0 and branchTaken=0: if ifWrite=1, IF/ID SHALL load a bubble {32'h0, 32'h0, valid=0}; if ifWrite=0, IF/ID SHALL hold.
REQ-019 In S_HOLD with ifWrite=1 and branchTaken=0: IF/ID SHALL load the hold buffer with valid=1, pc SHALL advance by 4 if pcWrite=1, and the next state SHALL be S_REQ.
REQ-020 When branchTaken=1 in any state: IF/ID SHALL flush to the bubble, pc SHALL become branchTarget, and any held or arriving data SHALL be discarded.
REQ-021 Redirect target state: S_DROP if in S_REQ with imemReady=0 or already in S_DROP with imemReady=0; otherwise S_REQ.
REQ-022 Priority SHALL be branchTaken over ifWrite/pcWrite=0; a flush overrides a stall.
REQ-023 In S_DROP, the response SHALL be discarded on imemReady=1 and the next state SHALL be S_REQ; IF/ID SHALL follow ifWrite as in REQ-018.
REQ-024 pc+4 and imemAddr+4 SHALL wrap modulo 2^32.

Reset
REQ-025 On reset: pc=RESET_PC, state S_REQ, ifIdInstr=0, ifIdPcPlus4=0, ifIdValid=0, hold buffer=0.
REQ-026 In the first cycle after reset, imemReq SHALL be 1 and imemAddr SHALL be RESET_PC.
REQ-027 Reset SHALL abandon any outstanding request; a late imemReady SHALL not be tracked.

Configuration
REQ-028 With IF_PERF_COUNTERS_EN defined, the block SHALL add outputs stallCount and flushCount (32 bits each).
REQ-029 With IF_PERF_COUNTERS_EN defined, stallCount SHALL increment each cycle ifWrite=0 and branchTaken=0, and flushCount SHALL increment each cycle branchTaken=1.
REQ-030 With IF_PERF_COUNTERS_EN defined, both counters SHALL saturate at 32'hFFFF_FFFF and reset to 0.
REQ-031 Without IF_PERF_COUNTERS_EN, neither the counter ports nor the counter logic SHALL exist.

Structure
REQ-032 Shared package if_pkg SHALL hold the state encoding (2 bits), NOP_INSTR=32'h0000_0000 and the default RESET_PC.
REQ-033 The IF/ID register with hold and flush SHALL be a sub-module if_id_reg; the FSM, PC and hold buffer SHALL stay in if_stage.

Verification
REQ-034 Bench SHALL cover: reset, then imemReady every cycle with ifWrite=pcWrite=1 -> imemAddr 0,4,8; ifIdPcPlus4 4,8,12; ifIdValid=1 from the 2nd cycle.
REQ-035 Bench SHALL cover: ifWrite=pcWrite=0 for 2 cycles coinciding with imemReady for addr 8 -> S_HOLD, IF/ID unchanged; release -> ifIdInstr=word@8, ifIdPcPlus4=12.
REQ-036 Bench SHALL cover: branchTaken with branchTarget=32'h100 while the addr-0x10 request is pending -> S_DROP, IF/ID bubble; the stale response is dropped; the next imemAddr is 32'h100.
REQ-037 Bench SHALL cover: branchTaken and ifWrite=0 in the same cycle -> flush wins: ifIdValid=0 and pc=branchTarget.
REQ-038 Bench SHALL cover: pc=32'hFFFF_FFFC fetch -> the next pc is 32'h0 and ifIdPcPlus4=32'h0.
REQ-039 Bench SHALL cover: with IF_PERF_COUNTERS_EN, 3 stall cycles and 1 flush -> stallCount=3, flushCount=1; reset clears both.
